// File: rtl/surf_cmd_receiver_if.sv
// Decoded-command bundle between the CMD line receiver and the SURF readout controller.
// Carries the serial CMD input plus the strobes, held fields and error counters.
interface surf_cmd_receiver_if #(
    parameter int BUF_WIDTH     = 2,
    parameter int ID_WIDTH      = 32,
    parameter int ERR_CNT_WIDTH = 8
);
    logic                     CMD_i;
    logic                     digitize_o;
    logic                     clear_o;
    logic                     evid_reset_o;
    logic [BUF_WIDTH-1:0]     buffer_o;
    logic [ID_WIDTH-1:0]      event_id_o;
    logic                     parity_err_o;
    logic                     frame_err_o;
    logic [ERR_CNT_WIDTH-1:0] parity_err_cnt_o;
    logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_o;
    logic                     busy_o;

    modport master (
        output CMD_i,
        input  digitize_o, clear_o, evid_reset_o, buffer_o, event_id_o,
        input  parity_err_o, frame_err_o, parity_err_cnt_o, frame_err_cnt_o, busy_o
    );

    modport slave (
        input  CMD_i,
        output digitize_o, clear_o, evid_reset_o, buffer_o, event_id_o,
        output parity_err_o, frame_err_o, parity_err_cnt_o, frame_err_cnt_o, busy_o
    );
endinterface

// File: rtl/surf_cmd_receiver.sv
// SURF CMD-line deframer: serial frames -> command strobes, held buffer/ID, saturating error counts.
// Stop bit on CMD_i to strobe is 3 cycles; no backpressure, strobes are single-cycle and must be taken.
module surf_cmd_receiver #(
    parameter int BUF_WIDTH     = 2,
    parameter int ID_WIDTH      = 32,
    parameter int RESYNC_BITS   = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic               clk125_i,
    input  logic               rst_i,
    surf_cmd_receiver_if.slave cmd_if
);
    localparam int DATA_W = 2 + BUF_WIDTH + ID_WIDTH;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int RS_W   = $clog2(RESYNC_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP, RESYNC} state_t;

    state_t                   state_q;
    logic [1:0]               sync_q;
    logic                     s;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [DATA_W-1:0]        pay_q;
    logic                     par_q;
    logic [RS_W-1:0]          rs_cnt_q;
    logic                     digitize_q, clear_q, evid_reset_q;
    logic                     parity_err_q, frame_err_q, busy_q;
    logic [BUF_WIDTH-1:0]     buffer_q;
    logic [ID_WIDTH-1:0]      event_id_q;
    logic [ERR_CNT_WIDTH-1:0] parity_err_cnt_q, parity_err_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_q, frame_err_cnt_d;
    logic [1:0]               typ;
    logic [BUF_WIDTH-1:0]     buf_fld;
    logic [ID_WIDTH-1:0]      id_fld;

    assign s       = sync_q[1];
    assign typ     = pay_q[DATA_W-1 -: 2];
    assign buf_fld = pay_q[ID_WIDTH +: BUF_WIDTH];
    assign id_fld  = pay_q[ID_WIDTH-1:0];

    assign parity_err_cnt_d = (&parity_err_cnt_q) ? parity_err_cnt_q
                                                  : parity_err_cnt_q + ERR_CNT_WIDTH'(1);
    assign frame_err_cnt_d  = (&frame_err_cnt_q) ? frame_err_cnt_q
                                                 : frame_err_cnt_q + ERR_CNT_WIDTH'(1);

    always_ff @(posedge clk125_i) begin
        if (rst_i) begin
            sync_q           <= '0;
            state_q          <= IDLE;
            bit_cnt_q        <= '0;
            pay_q            <= '0;
            par_q            <= 1'b0;
            rs_cnt_q         <= '0;
            digitize_q       <= 1'b0;
            clear_q          <= 1'b0;
            evid_reset_q     <= 1'b0;
            parity_err_q     <= 1'b0;
            frame_err_q      <= 1'b0;
            busy_q           <= 1'b0;
            buffer_q         <= '0;
            event_id_q       <= '0;
            parity_err_cnt_q <= '0;
            frame_err_cnt_q  <= '0;
        end else begin
            sync_q       <= {sync_q[0], cmd_if.CMD_i};
            digitize_q   <= 1'b0;
            clear_q      <= 1'b0;
            evid_reset_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    par_q     <= par_q ^ s;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    // The parity bit only feeds the accumulator; the payload keeps type/buffer/id.
                    if (bit_cnt_q == CNT_W'(DATA_W)) begin
                        state_q <= STOP;
                    end else begin
                        pay_q <= {pay_q[DATA_W-2:0], s};
                    end
                end
                STOP: begin
                    busy_q <= 1'b0;
                    if (s || typ == 2'b11) begin
                        frame_err_q     <= 1'b1;
                        frame_err_cnt_q <= frame_err_cnt_d;
                        rs_cnt_q        <= '0;
                        state_q         <= RESYNC;
                    end else begin
                        state_q <= IDLE;
                        if (par_q) begin
                            parity_err_q     <= 1'b1;
                            parity_err_cnt_q <= parity_err_cnt_d;
                        end else begin
                            case (typ)
                                2'b00: begin
                                    digitize_q <= 1'b1;
                                    buffer_q   <= buf_fld;
                                    event_id_q <= id_fld;
                                end
                                2'b01: begin
                                    clear_q  <= 1'b1;
                                    buffer_q <= buf_fld;
                                end
                                default: evid_reset_q <= 1'b1;
                            endcase
                        end
                    end
                end
                RESYNC: begin
                    // Only an unbroken run of idle bits re-arms start-bit detection.
                    if (s) begin
                        rs_cnt_q <= '0;
                    end else if (rs_cnt_q == RS_W'(RESYNC_BITS - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        rs_cnt_q <= rs_cnt_q + RS_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_if.digitize_o       = digitize_q;
    assign cmd_if.clear_o          = clear_q;
    assign cmd_if.evid_reset_o     = evid_reset_q;
    assign cmd_if.buffer_o         = buffer_q;
    assign cmd_if.event_id_o       = event_id_q;
    assign cmd_if.parity_err_o     = parity_err_q;
    assign cmd_if.frame_err_o      = frame_err_q;
    assign cmd_if.parity_err_cnt_o = parity_err_cnt_q;
    assign cmd_if.frame_err_cnt_o  = frame_err_cnt_q;
    assign cmd_if.busy_o           = busy_q;
endmodule

// File: tb/tb_surf_cmd_receiver.sv
// Bench for surf_cmd_receiver: bit streams are built frame by frame, a stream scanner predicts
// every output cycle by cycle, and a few literal checks pin the scanner itself.
module tb_surf_cmd_receiver;
    localparam int BW = 2;
    localparam int IW = 32;
    localparam int CW = 8;
    localparam int RB = 4;
    localparam int DW = 2 + BW + IW;
    localparam int FL = DW + 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    surf_cmd_receiver_if #(.BUF_WIDTH(BW), .ID_WIDTH(IW), .ERR_CNT_WIDTH(CW)) cif ();

    surf_cmd_receiver #(
        .BUF_WIDTH(BW), .ID_WIDTH(IW), .RESYNC_BITS(RB), .ERR_CNT_WIDTH(CW)
    ) dut (
        .clk125_i(clk),
        .rst_i   (rst),
        .cmd_if  (cif)
    );

    int tests = 0;
    int fails = 0;

    bit stream[$];
    string ph_name;

    logic [BW-1:0] m_buf;
    logic [IW-1:0] m_id;
    int m_pcnt, m_fcnt;

    int ph_dig, ph_clr, ph_evr, ph_perr, ph_ferr;
    int dig_at, clr_at, evr_at;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Parity is computed over the intended id; flip_mask then corrupts bits on the wire.
    task automatic push_frame(input logic [1:0] typ, input logic [BW-1:0] b, input logic [IW-1:0] id,
                              input logic [IW-1:0] flip_mask, input bit stop);
        logic [DW-1:0] d;
        bit p;
        p = ^{typ, b, id};
        d = {typ, b, id ^ flip_mask};
        stream.push_back(1'b1);
        for (int i = DW - 1; i >= 0; i--) stream.push_back(d[i]);
        stream.push_back(p);
        stream.push_back(stop);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) stream.push_back(1'b0);
    endtask

    task automatic run_phase(input string name);
        int L, p, t, ones, z;
        int kind[];
        bit bsy[];
        logic [BW-1:0] eb[];
        logic [IW-1:0] ei[];
        logic [1:0] typ;
        logic [BW-1:0] fb;
        logic [IW-1:0] fi;
        bit stop, rs;
        logic [63:0] exp_v, act_v;
        ph_name = name;
        ph_dig = 0; ph_clr = 0; ph_evr = 0; ph_perr = 0; ph_ferr = 0;
        dig_at = -1; clr_at = -1; evr_at = -1;
        push_idle(48);
        L = stream.size();
        kind = new[L];
        bsy = new[L];
        eb = new[L];
        ei = new[L];
        // Scan the stream as the receiver should see it: find starts, decode whole frames, skip resync runs.
        p = 0;
        while (p < L) begin
            if (!stream[p]) begin
                p++;
                continue;
            end
            if (p + FL > L) break;
            typ = {stream[p+1], stream[p+2]};
            fb = '0;
            fi = '0;
            ones = 0;
            for (int i = 1; i <= DW + 1; i++) ones += int'(stream[p+i]);
            for (int i = 0; i < BW; i++) fb = (fb << 1) | BW'(stream[p+3+i]);
            for (int i = 0; i < IW; i++) fi = (fi << 1) | IW'(stream[p+3+BW+i]);
            stop = stream[p+FL-1];
            for (int k = p + 3; k <= p + FL + 1; k++) bsy[k] = 1'b1;
            t = p + FL + 2;
            rs = 1'b0;
            if (stop || typ == 2'b11) begin
                kind[t] = 5;
                rs = 1'b1;
            end else if (ones % 2 != 0) begin
                kind[t] = 4;
            end else begin
                kind[t] = int'(typ) + 1;
                eb[t] = fb;
                ei[t] = fi;
            end
            p += FL;
            if (rs) begin
                z = 0;
                while (p < L && z < RB) begin
                    if (stream[p]) z = 0;
                    else z++;
                    p++;
                end
            end
        end
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            case (kind[k])
                1: begin m_buf = eb[k]; m_id = ei[k]; end
                2: m_buf = eb[k];
                4: m_pcnt = (m_pcnt < CMAX) ? m_pcnt + 1 : CMAX;
                5: m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
                default: ;
            endcase
            exp_v = {8'h0, kind[k] == 1, kind[k] == 2, kind[k] == 3, kind[k] == 4, kind[k] == 5,
                     bsy[k], m_buf, m_id, CW'(m_pcnt), CW'(m_fcnt)};
            act_v = {8'h0, cif.digitize_o, cif.clear_o, cif.evid_reset_o, cif.parity_err_o,
                     cif.frame_err_o, cif.busy_o, cif.buffer_o, cif.event_id_o,
                     cif.parity_err_cnt_o, cif.frame_err_cnt_o};
            check($sformatf("%s cyc %0d outputs", name, k), act_v, exp_v);
            if (cif.digitize_o) begin ph_dig++; if (dig_at < 0) dig_at = k; end
            if (cif.clear_o) begin ph_clr++; if (clr_at < 0) clr_at = k; end
            if (cif.evid_reset_o) begin ph_evr++; if (evr_at < 0) evr_at = k; end
            if (cif.parity_err_o) ph_perr++;
            if (cif.frame_err_o) ph_ferr++;
            cif.CMD_i = stream[k];
        end
        stream.delete();
    endtask

    task automatic rand_phase(input int nframes);
        logic [1:0] typ;
        logic [IW-1:0] mask;
        bit stop;
        for (int f = 0; f < nframes; f++) begin
            typ = 2'($urandom_range(3, 0));
            mask = ($urandom_range(4, 0) == 0) ? (IW'(1) << $urandom_range(IW - 1, 0)) : '0;
            stop = ($urandom_range(5, 0) == 0);
            push_frame(typ, BW'($urandom), IW'($urandom), mask, stop);
            if (stop && $urandom_range(2, 0) == 0) begin
                for (int j = 0; j < int'($urandom_range(12, 0)); j++) stream.push_back(bit'($urandom));
            end
            push_idle(int'($urandom_range(5, 0)));
        end
        run_phase("random");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.CMD_i = 1'b0;
        m_buf = '0; m_id = '0; m_pcnt = 0; m_fcnt = 0;
        repeat (4) @(negedge clk);
        check("reset_state",
              {cif.digitize_o, cif.clear_o, cif.evid_reset_o, cif.parity_err_o, cif.frame_err_o,
               cif.busy_o, cif.buffer_o, cif.event_id_o, cif.parity_err_cnt_o, cif.frame_err_cnt_o}, 64'h0);
        rst = 1'b0;

        push_idle(3);
        push_frame(2'b00, 2'd2, 32'h12345678, '0, 1'b0);
        run_phase("digitize");
        check("dig_count", ph_dig, 1);
        check("dig_at_stop_plus3", dig_at, 44);
        check("dig_buffer", cif.buffer_o, 2);
        check("dig_event_id", cif.event_id_o, 32'h12345678);
        check("dig_no_err", ph_perr + ph_ferr, 0);

        push_idle(2);
        push_frame(2'b01, 2'd1, 32'hDEADBEEF, '0, 1'b0);
        push_frame(2'b10, 2'd3, 32'h0F0F0F0F, '0, 1'b0);
        run_phase("clear_evr");
        check("clear_count", ph_clr, 1);
        check("evr_count", ph_evr, 1);
        check("clear_evr_spacing", evr_at - clr_at, 39);
        check("clear_buffer", cif.buffer_o, 1);
        check("clear_event_id_held", cif.event_id_o, 32'h12345678);

        push_idle(1);
        push_frame(2'b00, 2'd0, 32'h12345678, 32'h00000020, 1'b0);
        run_phase("parity_err");
        check("perr_count", ph_perr, 1);
        check("perr_no_dig", ph_dig, 0);
        check("perr_cnt", cif.parity_err_cnt_o, 1);
        check("perr_buffer_held", cif.buffer_o, 1);
        check("perr_id_held", cif.event_id_o, 32'h12345678);

        push_idle(1);
        push_frame(2'b00, 2'd1, 32'h11111111, '0, 1'b1);
        push_frame(2'b00, 2'd3, 32'hFFFFFFFF, '0, 1'b0);
        push_idle(4);
        push_frame(2'b00, 2'd2, 32'h0BADBEEF, '0, 1'b0);
        run_phase("stop_err_resync");
        check("ferr_count", ph_ferr, 1);
        check("resync_dig_count", ph_dig, 1);
        check("resync_event_id", cif.event_id_o, 32'h0BADBEEF);
        check("ferr_cnt", cif.frame_err_cnt_o, 1);

        push_frame(2'b11, 2'd1, 32'h00C0FFEE, '0, 1'b0);
        push_idle(2);
        run_phase("reserved_type");
        check("rsv_ferr_cnt", cif.frame_err_cnt_o, 2);
        check("rsv_no_cmd", ph_dig + ph_clr + ph_evr, 0);

        for (int i = 0; i < 300; i++)
            push_frame(2'($urandom_range(2, 0)), BW'($urandom), IW'($urandom),
                       IW'(1) << $urandom_range(IW - 1, 0), 1'b0);
        run_phase("parity_saturate");
        check("perr_saturated", cif.parity_err_cnt_o, 255);
        check("sat_buffer_held", cif.buffer_o, 2);
        check("sat_id_held", cif.event_id_o, 32'h0BADBEEF);

        rand_phase(60);

        push_frame(2'b00, 2'd3, 32'hA5A5A5A5, '0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cif.CMD_i = stream[k];
        end
        @(negedge clk);
        check("busy_mid_frame", cif.busy_o, 1);
        rst = 1'b1;
        cif.CMD_i = stream[20];
        for (int k = 21; k < FL; k++) begin
            @(negedge clk);
            cif.CMD_i = stream[k];
        end
        @(negedge clk);
        rst = 1'b0;
        cif.CMD_i = 1'b0;
        stream.delete();
        m_buf = '0; m_id = '0; m_pcnt = 0; m_fcnt = 0;
        check("post_reset_counters", {cif.parity_err_cnt_o, cif.frame_err_cnt_o}, 0);
        push_idle(2);
        push_frame(2'b00, 2'd1, 32'h600DF00D, '0, 1'b0);
        run_phase("after_reset");
        check("after_reset_dig", ph_dig, 1);
        check("after_reset_id", cif.event_id_o, 32'h600DF00D);
        check("after_reset_cnts", {cif.parity_err_cnt_o, cif.frame_err_cnt_o}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/surf_cmd_receiver.md
Name: surf_cmd_receiver

Overview:
- SURF-side receiver/decoder for the per-SURF serial CMD line driven by the TURF trigger interface.
- Deframes digitize, clear and event-ID-reset commands.
- Checks parity and framing.
- Presents decoded buffer number and event ID to the SURF readout logic as single-cycle strobes with held data.
- Sits between the CMD input pin and the SURF buffer/readout controller; all logic runs in the 125 MHz command domain.

Parameters:
- BUF_WIDTH, 2, width of buffer-number field.
- ID_WIDTH, 32, width of event-ID field.
- RESYNC_BITS, 4, consecutive idle (0) bits required after a framing error before a new start bit is accepted.
- ERR_CNT_WIDTH, 8, width of saturating error counters.

Ports:
- clk125_i  in  1  command clock; one CMD bit per cycle.
- rst_i  in  1  reset; synchronous, active-high.
- CMD_i  in  1  serial command line; idle low; asynchronous to clk125_i phase.
- digitize_o  out  1  one-cycle strobe: digitize command received.
- clear_o  out  1  one-cycle strobe: clear-buffer command received.
- evid_reset_o  out  1  one-cycle strobe: event-ID reset received.
- buffer_o  out  BUF_WIDTH  buffer field of last good frame.
- event_id_o  out  ID_WIDTH  event ID of last good digitize frame.
- parity_err_o  out  1  one-cycle strobe: frame dropped, bad parity.
- frame_err_o  out  1  one-cycle strobe: frame dropped, bad stop bit or reserved type.
- parity_err_cnt_o  out  ERR_CNT_WIDTH  saturating parity-error count.
- frame_err_cnt_o  out  ERR_CNT_WIDTH  saturating framing-error count.
- busy_o  out  1  high while a frame is being shifted in.

Behaviour:
- CMD_i passes through a 2-flop synchronizer; all decoding uses the synchronized bit `s`.
- Frame layout, MSB first: start(1), type[1:0], buffer[BUF_WIDTH-1:0], id[ID_WIDTH-1:0], parity, stop(0). Default frame is 39 bits.
- Type codes: 00 = digitize, 01 = clear buffer, 10 = event-ID reset, 11 = reserved (treated as a framing error).
- Parity is even over type+buffer+id+parity bit: the total count of ones in those bits must be even. Computed as a running XOR while shifting.
- FSM states:
  - IDLE: s=1 → SHIFT; clear the bit counter and parity accumulator.
  - SHIFT: shift s into the payload register and count bits. After the parity bit → STOP.
  - STOP: evaluate stop bit, parity and type. Good frame → IDLE. Framing error → RESYNC. Parity error with good stop → IDLE.
  - RESYNC: count consecutive s=0. Any s=1 restarts the count. On reaching RESYNC_BITS → IDLE.
- Back-to-back frames: the cycle after STOP, IDLE accepts a start bit, so zero idle bits are needed between good frames.
- Latency: stop bit present on CMD_i in cycle N → strobe and updated buffer_o / event_id_o registered and visible in cycle N+3.
- Good-frame outputs:
  - buffer_o updates on digitize and clear frames.
  - event_id_o updates on digitize frames only.
  - Exactly one of digitize_o / clear_o / evid_reset_o pulses.
- Bad-frame handling:
  - Outputs unchanged and no command strobe.
  - Error checks are prioritized: stop-bit error, then reserved type, then parity. Exactly one error strobe and one counter increment per bad frame.
  - Counters saturate at all-ones and never wrap.
- busy_o is high in SHIFT and STOP.
- Reset, including mid-frame: the partial frame is discarded and the FSM goes to IDLE. All outputs and counters become 0 and the synchronizer flops clear. The first strobe after reset requires a complete new frame.
- A start bit arriving during RESYNC only restarts the idle count; it is never decoded.

Test Plan:
- Reset, then a digitize frame with buffer=2, id=0x12345678 and correct parity → digitize_o pulses once at stop+3. buffer_o=2, event_id_o=0x12345678, no error strobes.
- Clear frame buffer=1, then evid-reset frame sent back-to-back with no gap → clear_o and evid_reset_o pulse 39 cycles apart. buffer_o=1, event_id_o unchanged.
- Digitize frame with one id bit flipped → parity_err_o pulses, parity_err_cnt_o=1, digitize_o stays low, buffer_o/event_id_o hold previous values.
- Frame with stop bit=1, followed immediately by a valid frame → frame_err_o pulses, the valid frame is ignored (RESYNC), and a valid frame sent after 4 idle bits decodes normally.
- Type=11 frame → frame_err_cnt_o increments. Drive 300 bad-parity frames → parity_err_cnt_o saturates at 255.
- Assert rst_i at bit 20 of a digitize frame and release; the remainder of that frame is then ignored (the mid-frame stop bit is absent). A subsequent valid frame then decodes with all counters 0.
